// File: rtl/blink_requester_if.sv
// Purpose: groups the requester's event inputs, blinker handshake and status flags.
// Latency: none, wiring only.
// Backpressure: none here; the blinker paces the requester through done_blinking.
// Ports (master = blink_requester):
//   req_error, req_success  in   one-cycle blink events (type 0 / type 1)
//   clear_flags             in   synchronous clear of the sticky flags
//   done_blinking           in   acknowledge from the blinker
//   start_blinking          out  request to the blinker
//   blinkType               out  0 = error pattern, 1 = success pattern
//   busy, overflow, timeout_err  out  status
interface blink_requester_if;
    logic req_error;
    logic req_success;
    logic clear_flags;
    logic start_blinking;
    logic blinkType;
    logic done_blinking;
    logic busy;
    logic overflow;
    logic timeout_err;

    modport master (
        input  req_error,
        input  req_success,
        input  clear_flags,
        input  done_blinking,
        output start_blinking,
        output blinkType,
        output busy,
        output overflow,
        output timeout_err
    );

    modport slave (
        output req_error,
        output req_success,
        output clear_flags,
        output done_blinking,
        input  start_blinking,
        input  blinkType,
        input  busy,
        input  overflow,
        input  timeout_err
    );
endinterface

// File: rtl/blink_requester.sv
// Purpose: queues blink events and replays them as a four-phase start/done handshake.
// Latency: request in cycle N -> blinkType valid at N+2 -> start_blinking high at N+3.
// Backpressure: DEPTH-entry queue; pushes to a full queue are dropped and set overflow.
// Ports:
//   hwclk   in  system clock
//   rst_n   in  asynchronous active-low reset
//   bus     blink_requester_if.master (events, handshake, status flags)
module blink_requester #(
    parameter int unsigned DEPTH   = 4,
    parameter logic [31:0] TIMEOUT = 32'd48000000
) (
    input  logic                  hwclk,
    input  logic                  rst_n,
    blink_requester_if.master     bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETUP   = 2'd1,
        REQ     = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [DEPTH-1:0] mem;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic [CW-1:0]   free_slots;
    logic [31:0]     wd;
    logic            wd_expired;
    logic            pop;
    logic            acc_err;
    logic            acc_suc;
    logic            drop;
    logic            to_fire;
    logic            start_c;
    logic            blink_type_q;
    logic            overflow_q;
    logic            timeout_q;

    // A pop in this cycle frees its slot for this cycle's pushes, so a full
    // queue that is being drained still accepts one new entry.
    assign free_slots = CW'(DEPTH) - count + {{(CW-1){1'b0}}, pop};

    // Error is pushed ahead of success when both arrive together.
    assign acc_err = bus.req_error   && (free_slots != '0);
    assign acc_suc = bus.req_success && (free_slots > {{(CW-1){1'b0}}, acc_err});
    assign drop    = (bus.req_error && !acc_err) || (bus.req_success && !acc_suc);

    assign wd_expired = (wd == TIMEOUT - 32'd1);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge hwclk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------- FSM: next state and outputs ----------------
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        to_fire   = 1'b0;
        start_c   = 1'b0;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    pop       = 1'b1;
                    state_nxt = SETUP;
                end
            end
            // One dead cycle so blinkType settles before start rises; the
            // blinker samples the type on the start edge.
            SETUP: begin
                state_nxt = REQ;
            end
            REQ: begin
                start_c = 1'b1;
                if (bus.done_blinking) begin
                    state_nxt = RELEASE;
                end else if (wd_expired) begin
                    to_fire   = 1'b1;
                    state_nxt = RELEASE;
                end
            end
            RELEASE: begin
                if (!bus.done_blinking) begin
                    state_nxt = IDLE;
                end else if (wd_expired) begin
                    to_fire   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // ---------------- Watchdog ----------------
    // Restarts from zero on every state change, so each handshake phase
    // gets its own TIMEOUT-cycle budget.
    always_ff @(posedge hwclk or negedge rst_n) begin
        if (!rst_n) begin
            wd <= '0;
        end else if (state_nxt != state) begin
            wd <= '0;
        end else if (state == REQ || state == RELEASE) begin
            wd <= wd + 32'd1;
        end else begin
            wd <= '0;
        end
    end

    // ---------------- Event queue ----------------
    always_ff @(posedge hwclk or negedge rst_n) begin
        if (!rst_n) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (acc_err) begin
                mem[wr_ptr] <= 1'b0;
            end
            if (acc_suc) begin
                mem[wr_ptr + AW'(acc_err)] <= 1'b1;
            end
            wr_ptr <= wr_ptr + AW'(acc_err) + AW'(acc_suc);
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(acc_err) + CW'(acc_suc) - CW'(pop);
        end
    end

    // blinkType only changes when an entry is taken, i.e. entering SETUP.
    always_ff @(posedge hwclk or negedge rst_n) begin
        if (!rst_n) begin
            blink_type_q <= 1'b0;
        end else if (pop) begin
            blink_type_q <= mem[rd_ptr];
        end
    end

    // ---------------- Sticky flags ----------------
    // A set event in the same cycle as clear_flags keeps the flag high.
    always_ff @(posedge hwclk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            if (drop) begin
                overflow_q <= 1'b1;
            end else if (bus.clear_flags) begin
                overflow_q <= 1'b0;
            end
            if (to_fire) begin
                timeout_q <= 1'b1;
            end else if (bus.clear_flags) begin
                timeout_q <= 1'b0;
            end
        end
    end

    // start is decoded from state so an asynchronous reset drops it at once.
    assign bus.start_blinking = start_c;
    assign bus.blinkType      = blink_type_q;
    assign bus.busy           = (state != IDLE) || (count != '0);
    assign bus.overflow       = overflow_q;
    assign bus.timeout_err    = timeout_q;
endmodule

// File: tb/tb_blink_requester.sv
module tb_blink_requester;
    logic hwclk = 1'b0;
    logic rst_n = 1'b0;

    blink_requester_if bif ();

    blink_requester #(
        .DEPTH   (4),
        .TIMEOUT (32'd16)
    ) dut (
        .hwclk (hwclk),
        .rst_n (rst_n),
        .bus   (bif)
    );

    always #5 hwclk = ~hwclk;

    int checks = 0;
    int fails  = 0;
    int hs_count = 0;
    logic hs_types[$];

    // Record every handshake and the type presented with its rising start.
    always @(posedge bif.start_blinking) begin
        hs_types.push_back(bif.blinkType);
        hs_count++;
    end

    task automatic tick();
        @(posedge hwclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for start, checks the type, then completes the
    // handshake. 'waited' is the number of low cycles seen before start rose.
    task automatic serve(input logic exp_type, input string tag, output int waited);
        int n;
        n = 0;
        while (bif.start_blinking !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        waited = n;
        check({tag, "_start"}, bif.start_blinking, 1'b1);
        check({tag, "_type"}, bif.blinkType, exp_type);
        bif.done_blinking = 1'b1;
        tick();
        check({tag, "_start_fall"}, bif.start_blinking, 1'b0);
        bif.done_blinking = 1'b0;
        tick();
    endtask

    task automatic pulse_req(input logic err, input logic suc);
        bif.req_error   = err;
        bif.req_success = suc;
        tick();
        bif.req_error   = 1'b0;
        bif.req_success = 1'b0;
    endtask

    initial begin
        int w;
        int base;
        bif.req_error     = 1'b0;
        bif.req_success   = 1'b0;
        bif.clear_flags   = 1'b0;
        bif.done_blinking = 1'b0;

        // ---- reset state ----
        repeat (3) tick();
        check("rst_start", bif.start_blinking, 1'b0);
        check("rst_type", bif.blinkType, 1'b0);
        check("rst_busy", bif.busy, 1'b0);
        check("rst_overflow", bif.overflow, 1'b0);
        check("rst_timeout", bif.timeout_err, 1'b0);
        rst_n = 1'b1;
        repeat (2) tick();

        // ---- single error request, exact cycle timing (C = pulse cycle) ----
        pulse_req(1'b1, 1'b0);                               // now C+1
        check("t1_busy_c1", bif.busy, 1'b1);
        check("t1_start_c1", bif.start_blinking, 1'b0);
        tick();                                              // C+2, SETUP
        check("t1_start_c2", bif.start_blinking, 1'b0);
        check("t1_type_c2", bif.blinkType, 1'b0);
        tick();                                              // C+3, REQ
        check("t1_start_c3", bif.start_blinking, 1'b1);
        repeat (7) tick();                                   // C+10
        check("t1_start_c10", bif.start_blinking, 1'b1);
        bif.done_blinking = 1'b1;
        tick();                                              // C+11
        check("t1_start_c11", bif.start_blinking, 1'b0);
        check("t1_busy_c11", bif.busy, 1'b1);
        tick();
        tick();                                              // C+13
        check("t1_busy_c13", bif.busy, 1'b1);
        bif.done_blinking = 1'b0;
        tick();                                              // C+14, IDLE
        check("t1_busy_c14", bif.busy, 1'b0);
        check("t1_hs", hs_count, 1);

        // ---- simultaneous error + success ----
        base = hs_count;
        pulse_req(1'b1, 1'b1);
        serve(1'b0, "t2_first", w);
        serve(1'b1, "t2_second", w);
        check("t2_low_gap", w + 1, 3);
        check("t2_overflow", bif.overflow, 1'b0);
        check("t2_hs", hs_count - base, 2);
        check("t2_order0", hs_types[base], 1'b0);
        check("t2_order1", hs_types[base+1], 1'b1);
        repeat (3) tick();
        check("t2_type_held", bif.blinkType, 1'b1);
        check("t2_busy", bif.busy, 1'b0);

        // ---- overflow with blinker held off in REQ ----
        base = hs_count;
        pulse_req(1'b1, 1'b0);
        tick();
        tick();
        check("t3_in_req", bif.start_blinking, 1'b1);
        for (int i = 0; i < 5; i++) pulse_req(1'b0, 1'b1);
        check("t3_overflow_set", bif.overflow, 1'b1);
        bif.clear_flags = 1'b1;
        tick();
        bif.clear_flags = 1'b0;
        check("t3_overflow_clr", bif.overflow, 1'b0);
        bif.clear_flags = 1'b1;
        bif.req_success = 1'b1;
        tick();
        bif.clear_flags = 1'b0;
        bif.req_success = 1'b0;
        check("t3_set_wins", bif.overflow, 1'b1);
        serve(1'b0, "t3_err", w);
        for (int i = 0; i < 4; i++) serve(1'b1, "t3_suc", w);
        repeat (10) tick();
        check("t3_hs", hs_count - base, 5);
        check("t3_busy", bif.busy, 1'b0);
        bif.clear_flags = 1'b1;
        tick();
        bif.clear_flags = 1'b0;
        check("t3_overflow_final", bif.overflow, 1'b0);

        // ---- pointer wrap: 10 alternating requests, each served ----
        base = hs_count;
        for (int i = 0; i < 10; i++) begin
            pulse_req(i[0] == 1'b0, i[0] == 1'b1);
            serve(i[0], "t4_hs", w);
        end
        repeat (3) tick();
        check("t4_hs", hs_count - base, 10);
        for (int i = 0; i < 10; i++) check("t4_seq", hs_types[base+i], i[0]);
        check("t4_overflow", bif.overflow, 1'b0);

        // ---- timeout in REQ, then done stuck high in RELEASE ----
        pulse_req(1'b0, 1'b1);                               // C+1
        pulse_req(1'b1, 1'b0);                               // C+2
        tick();                                              // C+3, REQ wd=0
        check("t5_req", bif.start_blinking, 1'b1);
        repeat (15) tick();                                  // C+18, last REQ cycle
        check("t5_start_c18", bif.start_blinking, 1'b1);
        check("t5_to_c18", bif.timeout_err, 1'b0);
        tick();                                              // C+19, RELEASE
        check("t5_start_c19", bif.start_blinking, 1'b0);
        check("t5_to_c19", bif.timeout_err, 1'b1);
        bif.clear_flags = 1'b1;
        tick();                                              // C+20, IDLE
        bif.clear_flags = 1'b0;
        check("t5_to_clr", bif.timeout_err, 1'b0);
        tick();
        tick();                                              // C+22, next entry in REQ
        check("t5_next_start", bif.start_blinking, 1'b1);
        check("t5_next_type", bif.blinkType, 1'b0);
        bif.done_blinking = 1'b1;
        tick();                                              // C+23, RELEASE wd=0
        check("t5_rel_start", bif.start_blinking, 1'b0);
        repeat (15) tick();                                  // C+38, last RELEASE cycle
        check("t5_rel_busy", bif.busy, 1'b1);
        check("t5_rel_to", bif.timeout_err, 1'b0);
        bif.clear_flags = 1'b1;
        tick();                                              // C+39, IDLE
        bif.clear_flags = 1'b0;
        check("t5_rel_idle", bif.busy, 1'b0);
        check("t5_rel_to_set", bif.timeout_err, 1'b1);
        bif.done_blinking = 1'b0;
        tick();

        // ---- reset mid-REQ with two entries queued ----
        pulse_req(1'b0, 1'b1);
        pulse_req(1'b1, 1'b0);
        pulse_req(1'b1, 1'b0);
        w = 0;
        while (bif.start_blinking !== 1'b1 && w < 20) begin
            tick();
            w++;
        end
        check("t6_start_before", bif.start_blinking, 1'b1);
        check("t6_type_before", bif.blinkType, 1'b1);
        base = hs_count;
        rst_n = 1'b0;
        #1;
        check("t6_start_async", bif.start_blinking, 1'b0);
        check("t6_busy", bif.busy, 1'b0);
        check("t6_type", bif.blinkType, 1'b0);
        check("t6_overflow", bif.overflow, 1'b0);
        check("t6_timeout", bif.timeout_err, 1'b0);
        tick();
        tick();
        rst_n = 1'b1;
        repeat (20) tick();
        check("t6_no_hs", hs_count - base, 0);
        check("t6_busy_after", bif.busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
